ball_motion_scheduler: RTL and testbench



---
 rtl/ball_motion_scheduler_if.sv | 36 +++
 rtl/ball_motion_scheduler.sv | 213 +++++++++++++++++++++
 tb/tb_ball_motion_scheduler.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/ball_motion_scheduler_if.sv
// rtl/ball_motion_scheduler_if.sv - bundle of beam, control and ball status signals for ball_motion_scheduler
// Purpose: groups every non-clock, non-reset signal of ball_motion_scheduler.
// Signals:
//   frame_tick  one-cycle pulse at start of vertical blank
//   hpos, vpos  beam position from the hvsync generator (16 bits each)
//   paddle_x    paddle left edge X
//   serve       level request to start a game from IDLE
//   ball_x/y    ball top-left corner
//   ball_gfx    beam inside the ball square (registered)
//   paddle_gfx  beam inside the paddle rectangle (registered)
//   phase       0 IDLE, 1 SERVE, 2 PLAY, 3 MISS
//   miss_pulse  one-cycle pulse on entering MISS
// Modports: master drives the beam/control side, slave is the scheduler.
interface ball_motion_scheduler_if;
  logic        frame_tick;
  logic [15:0] hpos;
  logic [15:0] vpos;
  logic [7:0]  paddle_x;
  logic        serve;
  logic [7:0]  ball_x;
  logic [7:0]  ball_y;
  logic        ball_gfx;
  logic        paddle_gfx;
  logic [1:0]  phase;
  logic        miss_pulse;

  modport master (
    output frame_tick, hpos, vpos, paddle_x, serve,
    input  ball_x, ball_y, ball_gfx, paddle_gfx, phase, miss_pulse
  );

  modport slave (
    input  frame_tick, hpos, vpos, paddle_x, serve,
    output ball_x, ball_y, ball_gfx, paddle_gfx, phase, miss_pulse
  );
endinterface

// File: rtl/ball_motion_scheduler.sv
// rtl/ball_motion_scheduler.sv - frame-synchronous ball position, collision and game-phase controller
// Purpose: holds registered ball X/Y, moves the ball once per frame_tick,
//   detects paddle overlap during scan-out and sequences IDLE/SERVE/PLAY/MISS.
// Ports:
//   clk    pixel clock
//   reset  synchronous, active-high
//   io     ball_motion_scheduler_if.slave (beam, paddle, serve in; ball, gfx, phase out)
// Optional feature macro: BALL_SPEEDUP_EN (every 4th paddle hit raises speed, max 3).
module ball_motion_scheduler #(
  parameter int unsigned BALL_SIZE    = 4,
  parameter int unsigned H_LIMIT      = 255,
  parameter int unsigned V_LIMIT      = 239,
  parameter int unsigned SERVE_X      = 128,
  parameter int unsigned SERVE_Y      = 64,
  parameter int unsigned PADDLE_Y     = 224,
  parameter int unsigned PADDLE_W     = 32,
  parameter int unsigned SERVE_FRAMES = 60
) (
  input logic                   clk,
  input logic                   reset,
  ball_motion_scheduler_if.slave io
);

  localparam logic [1:0] PH_IDLE  = 2'd0;
  localparam logic [1:0] PH_SERVE = 2'd1;
  localparam logic [1:0] PH_PLAY  = 2'd2;
  localparam logic [1:0] PH_MISS  = 2'd3;

  localparam int unsigned       CNT_W  = $clog2(SERVE_FRAMES + 1);
  localparam logic signed [9:0] X_MAX  = 10'(H_LIMIT - BALL_SIZE + 1);
  localparam logic signed [9:0] Y_LIM  = 10'(V_LIMIT);
  localparam logic signed [9:0] SIZE_S = 10'(BALL_SIZE);

  logic [1:0]       phase_q, phase_d;
  logic [7:0]       ball_x_q, ball_x_d;
  logic [7:0]       ball_y_q, ball_y_d;
  logic             dx_neg_q, dx_neg_d;
  logic             dy_neg_q, dy_neg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hit_q, hit_d;
  logic             ball_gfx_q, ball_gfx_d;
  logic             paddle_gfx_q, paddle_gfx_d;
  logic             miss_pulse_q, miss_pulse_d;
  logic [1:0]       speed;

`ifdef BALL_SPEEDUP_EN
  logic [1:0] speed_q, speed_d;
  logic [1:0] hit_cnt_q, hit_cnt_d;
  assign speed = speed_q;
`else
  assign speed = 2'd1;
`endif

  // Beam comparisons use the full 16-bit beam width so a ball or paddle
  // touching X=255 does not wrap its right edge back to zero.
  logic [15:0] bx_lo, bx_hi, by_lo, by_hi, px_lo, px_hi;
  always_comb begin
    bx_lo        = {8'h00, ball_x_q};
    bx_hi        = bx_lo + 16'(BALL_SIZE);
    by_lo        = {8'h00, ball_y_q};
    by_hi        = by_lo + 16'(BALL_SIZE);
    px_lo        = {8'h00, io.paddle_x};
    px_hi        = px_lo + 16'(PADDLE_W);
    ball_gfx_d   = (io.hpos >= bx_lo) && (io.hpos < bx_hi) &&
                   (io.vpos >= by_lo) && (io.vpos < by_hi);
    paddle_gfx_d = (io.hpos >= px_lo) && (io.hpos < px_hi) &&
                   (io.vpos >= 16'(PADDLE_Y)) && (io.vpos < 16'(PADDLE_Y + 4));
  end

  logic signed [9:0] step, nx, ny;
  assign step = {8'h00, speed};
  assign nx   = $signed({2'b00, ball_x_q}) + (dx_neg_q ? -step : step);
  assign ny   = $signed({2'b00, ball_y_q}) + (dy_neg_q ? -step : step);

  logic [7:0] new_x;
  logic       new_dx_neg;
  logic       to_miss;

  always_comb begin
    phase_d      = phase_q;
    ball_x_d     = ball_x_q;
    ball_y_d     = ball_y_q;
    dx_neg_d     = dx_neg_q;
    dy_neg_d     = dy_neg_q;
    cnt_d        = cnt_q;
    miss_pulse_d = 1'b0;
    new_x        = nx[7:0];
    new_dx_neg   = dx_neg_q;
    to_miss      = 1'b0;
`ifdef BALL_SPEEDUP_EN
    speed_d      = speed_q;
    hit_cnt_d    = hit_cnt_q;
`endif
    // The flag accumulates overlap over a whole scan and is consumed by the
    // frame_tick that ends it.
    hit_d = io.frame_tick ? 1'b0
                          : (hit_q | (ball_gfx_q & paddle_gfx_q & (phase_q == PH_PLAY)));

    case (phase_q)
      PH_IDLE: begin
        ball_x_d = 8'(SERVE_X);
        ball_y_d = 8'(SERVE_Y);
        if (io.serve) begin
          phase_d  = PH_SERVE;
          cnt_d    = '0;
          dy_neg_d = 1'b0;
`ifdef BALL_SPEEDUP_EN
          speed_d   = 2'd1;
          hit_cnt_d = 2'd0;
`endif
        end
      end
      PH_SERVE: begin
        ball_x_d = 8'(SERVE_X);
        ball_y_d = 8'(SERVE_Y);
        dy_neg_d = 1'b0;
        if (io.frame_tick) begin
          if (cnt_q == CNT_W'(SERVE_FRAMES - 1)) phase_d = PH_PLAY;
          else                                   cnt_d   = cnt_q + 1'b1;
        end
      end
      PH_PLAY: begin
        if (io.frame_tick) begin
          if (nx < 10'sd0) begin
            new_x      = 8'd0;
            new_dx_neg = 1'b0;
          end else if (nx > X_MAX) begin
            new_x      = X_MAX[7:0];
            new_dx_neg = 1'b1;
          end
          if (ny < 10'sd0) begin
            ball_y_d = 8'd0;
            dy_neg_d = 1'b0;
          end else if (hit_q && !dy_neg_q) begin
            ball_y_d = 8'(PADDLE_Y - BALL_SIZE);
            dy_neg_d = 1'b1;
`ifdef BALL_SPEEDUP_EN
            hit_cnt_d = hit_cnt_q + 2'd1;
            if (hit_cnt_q == 2'd3 && speed_q != 2'd3) speed_d = speed_q + 2'd1;
`endif
          end else if (ny + SIZE_S > Y_LIM) begin
            to_miss = 1'b1;
          end else begin
            ball_y_d = ny[7:0];
          end
          // A miss freezes the ball where it was last drawn.
          if (to_miss) begin
            phase_d      = PH_MISS;
            miss_pulse_d = 1'b1;
          end else begin
            ball_x_d = new_x;
            dx_neg_d = new_dx_neg;
          end
        end
      end
      default: begin
        if (io.frame_tick) begin
          phase_d  = PH_SERVE;
          cnt_d    = '0;
          ball_x_d = 8'(SERVE_X);
          ball_y_d = 8'(SERVE_Y);
          dy_neg_d = 1'b0;
`ifdef BALL_SPEEDUP_EN
          speed_d   = 2'd1;
          hit_cnt_d = 2'd0;
`endif
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q      <= PH_IDLE;
      ball_x_q     <= 8'(SERVE_X);
      ball_y_q     <= 8'(SERVE_Y);
      dx_neg_q     <= 1'b0;
      dy_neg_q     <= 1'b0;
      cnt_q        <= '0;
      hit_q        <= 1'b0;
      ball_gfx_q   <= 1'b0;
      paddle_gfx_q <= 1'b0;
      miss_pulse_q <= 1'b0;
`ifdef BALL_SPEEDUP_EN
      speed_q      <= 2'd1;
      hit_cnt_q    <= 2'd0;
`endif
    end else begin
      phase_q      <= phase_d;
      ball_x_q     <= ball_x_d;
      ball_y_q     <= ball_y_d;
      dx_neg_q     <= dx_neg_d;
      dy_neg_q     <= dy_neg_d;
      cnt_q        <= cnt_d;
      hit_q        <= hit_d;
      ball_gfx_q   <= ball_gfx_d;
      paddle_gfx_q <= paddle_gfx_d;
      miss_pulse_q <= miss_pulse_d;
`ifdef BALL_SPEEDUP_EN
      speed_q      <= speed_d;
      hit_cnt_q    <= hit_cnt_d;
`endif
    end
  end

  assign io.phase      = phase_q;
  assign io.ball_x     = ball_x_q;
  assign io.ball_y     = ball_y_q;
  assign io.ball_gfx   = ball_gfx_q;
  assign io.paddle_gfx = paddle_gfx_q;
  assign io.miss_pulse = miss_pulse_q;

endmodule

// File: tb/tb_ball_motion_scheduler.sv
// tb/tb_ball_motion_scheduler.sv - scoreboard bench for ball_motion_scheduler
module tb_ball_motion_scheduler;

  localparam int PARK = 400;
  localparam bit [3:0] M_PH = 4'b0001, M_POS = 4'b0010, M_MISS = 4'b0100, M_GFX = 4'b1000;
  localparam bit [3:0] M_FRAME = M_PH | M_POS | M_MISS;

  typedef struct {
    string    name;
    bit [3:0] mask;
    int       ph;
    int       x;
    int       y;
    int       mp;
    int       bg;
    int       pg;
  } exp_t;

  typedef struct {
    int h;
    int v;
    int bg;
    int pg;
  } pr_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic probe = 1'b0;
  int   n_pass = 0;
  int   n_total = 0;
  int   miss_seen = 0;
  exp_t exp_q[$];

  pr_t idle_pr[11] = '{
    '{128, 64, 1, 0}, '{131, 67, 1, 0}, '{132, 64, 0, 0}, '{127, 64, 0, 0},
    '{128, 68, 0, 0}, '{131, 63, 0, 0}, '{0, 224, 0, 1},  '{31, 227, 0, 1},
    '{32, 224, 0, 0}, '{0, 228, 0, 0},  '{5, 223, 0, 0}
  };
  pr_t edge_pr[4] = '{
    '{255, 224, 0, 1}, '{271, 227, 0, 1}, '{272, 224, 0, 0}, '{239, 224, 0, 0}
  };

  ball_motion_scheduler_if bif ();

  ball_motion_scheduler dut (
    .clk   (clk),
    .reset (reset),
    .io    (bif)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
  endtask

  task automatic push(input string n, input bit [3:0] m, input int ph, input int x,
                      input int y, input int mp, input int bg, input int pg);
    exp_t e;
    e.name = n; e.mask = m; e.ph = ph; e.x = x; e.y = y; e.mp = mp; e.bg = bg; e.pg = pg;
    exp_q.push_back(e);
  endtask

  task automatic probe_gfx(input string n, input int h, input int v, input int bg, input int pg);
    bif.hpos = 16'(h);
    bif.vpos = 16'(v);
    probe = 1'b1;
    push(n, M_GFX, 0, 0, 0, 0, bg, pg);
    @(negedge clk);
    probe = 1'b0;
    bif.hpos = 16'(PARK);
    bif.vpos = 16'(PARK);
  endtask

  task automatic probe_status(input string n, input int ph, input int x, input int y, input int mp);
    probe = 1'b1;
    push(n, M_FRAME, ph, x, y, mp, 0, 0);
    @(negedge clk);
    probe = 1'b0;
  endtask

  // One short frame: optional beam position, a parked cycle, then frame_tick.
  task automatic frame(input string n, input int ph, input int x, input int y, input int mp,
                       input int bh, input int bv);
    bif.hpos = 16'(bh);
    bif.vpos = 16'(bv);
    @(negedge clk);
    bif.hpos = 16'(PARK);
    bif.vpos = 16'(PARK);
    @(negedge clk);
    push(n, M_FRAME, ph, x, y, mp, 0, 0);
    bif.frame_tick = 1'b1;
    @(negedge clk);
    bif.frame_tick = 1'b0;
  endtask

  task automatic do_reset(input string n);
    reset = 1'b1;
    bif.frame_tick = 1'b1;
    probe = 1'b1;
    push(n, M_FRAME | M_GFX, 0, 128, 64, 0, 0, 0);
    @(negedge clk);
    probe = 1'b0;
    bif.frame_tick = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic serve_to_play(input string n);
    bif.serve = 1'b1;
    probe_status({n, "_serve_entry"}, 1, 128, 64, 0);
    for (int i = 1; i <= 60; i++) begin
      if (i == 3) bif.serve = 1'b0;
      frame($sformatf("%s_serve%0d", n, i), (i == 60) ? 2 : 1, 128, 64, 0, PARK, PARK);
    end
  endtask

  // Hand-derived trajectory from serve with dx=+1, dy=+1, no paddle contact.
  function automatic void traj(input int k, output int x, output int y);
    y = 64 + k;
    if (k <= 124)      x = 128 + k;
    else if (k == 125) x = 252;
    else               x = 377 - k;
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      if (probe || (bif.frame_tick && !reset)) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL scoreboard_underflow actual=empty expected=entry");
        end else begin
          e = exp_q.pop_front();
          @(negedge clk);
          if (e.mask[0]) chk({e.name, ".phase"}, int'(bif.phase), e.ph);
          if (e.mask[1]) begin
            chk({e.name, ".ball_x"}, int'(bif.ball_x), e.x);
            chk({e.name, ".ball_y"}, int'(bif.ball_y), e.y);
          end
          if (e.mask[2]) chk({e.name, ".miss_pulse"}, int'(bif.miss_pulse), e.mp);
          if (e.mask[3]) begin
            chk({e.name, ".ball_gfx"}, int'(bif.ball_gfx), e.bg);
            chk({e.name, ".paddle_gfx"}, int'(bif.paddle_gfx), e.pg);
          end
        end
      end
    end
  end

  initial begin : miss_counter
    forever begin
      @(negedge clk);
      if (bif.miss_pulse === 1'b1) miss_seen++;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int x, y;
    bif.frame_tick = 1'b0;
    bif.serve      = 1'b0;
    bif.paddle_x   = 8'd0;
    bif.hpos       = 16'(PARK);
    bif.vpos       = 16'(PARK);
    repeat (3) @(negedge clk);
    do_reset("reset");

    for (int i = 0; i < 11; i++)
      probe_gfx($sformatf("idle_gfx%0d", i), idle_pr[i].h, idle_pr[i].v, idle_pr[i].bg, idle_pr[i].pg);
    bif.paddle_x = 8'd240;
    for (int i = 0; i < 4; i++)
      probe_gfx($sformatf("edge_gfx%0d", i), edge_pr[i].h, edge_pr[i].v, edge_pr[i].bg, edge_pr[i].pg);
    bif.paddle_x = 8'd0;

    for (int i = 0; i < 10; i++) frame($sformatf("idle_frame%0d", i), 0, 128, 64, 0, PARK, PARK);

    // Game 1: right-wall bounce then a miss at the bottom.
    serve_to_play("g1");
    for (int k = 1; k <= 172; k++) begin
      traj(k, x, y);
      if (k == 172) frame("g1_miss", 3, 206, 235, 1, PARK, PARK);
      else          frame($sformatf("g1_k%0d", k), 2, x, y, 0, PARK, PARK);
      if (k == 125) begin
        probe_gfx("wall_gfx_in", 255, 189, 1, 0);
        probe_gfx("wall_gfx_out", 256, 189, 0, 0);
      end
    end
    probe_status("miss_pulse_end", 3, 206, 235, 0);
    frame("miss_to_serve", 1, 128, 64, 0, PARK, PARK);
    frame("serve_hold_a", 1, 128, 64, 0, PARK, PARK);
    frame("serve_hold_b", 1, 128, 64, 0, PARK, PARK);
    do_reset("reset_mid_serve");

    // Game 2: paddle catches the ball just above the paddle line.
    bif.paddle_x = 8'd210;
    serve_to_play("g2");
    for (int k = 1; k <= 160; k++) begin
      traj(k, x, y);
      if (k >= 158) begin
        x = 377 - k;
        y = 378 - k;
      end
      if (k == 158) frame("g2_paddle_hit", 2, x, y, 0, 221, 224);
      else          frame($sformatf("g2_k%0d", k), 2, x, y, 0, PARK, PARK);
    end

    do_reset("reset_mid_play");
    frame("idle_after_reset", 0, 128, 64, 0, PARK, PARK);

    repeat (4) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    chk("miss_pulse_count", miss_seen, 1);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
